// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: default sizing,
// FSM state encoding and the redirect-type encoding.
package pc_gen_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int STEP       = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_WAIT_GNT = 2'd2;

    typedef enum logic {
        REDIR_JUMP = 1'b0,
        REDIR_INT  = 1'b1
    } redir_type_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer that remembers a redirect arriving while the
// instruction bus has not yet accepted the current fetch.
module pc_redirect_buf #(
    parameter int ADDR_WIDTH = pc_gen_pkg::ADDR_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_hold,
    input  logic                    i_consume,
    input  logic                    i_flush_int,
    input  logic [ADDR_WIDTH-1:0]   i_int_pc,
    input  logic                    i_flush_jump,
    input  logic [ADDR_WIDTH-1:0]   i_jump_pc,
    output logic                    o_valid,
    output logic [ADDR_WIDTH-1:0]   o_target,
    output pc_gen_pkg::redir_type_e o_type
);
    import pc_gen_pkg::*;

    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_target;
    redir_type_e           r_type;

    // A pending interrupt is never displaced by a later jump.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_target <= '0;
            r_type   <= REDIR_JUMP;
        end else if (i_hold) begin
            if (i_flush_int) begin
                r_valid  <= 1'b1;
                r_target <= i_int_pc;
                r_type   <= REDIR_INT;
            end else if (i_flush_jump && !(r_valid && (r_type == REDIR_INT))) begin
                r_valid  <= 1'b1;
                r_target <= i_jump_pc;
                r_type   <= REDIR_JUMP;
            end
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;
    assign o_type   = r_type;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential stepping, stall hold,
// interrupt/jump redirects with a pending slot while the bus is busy.
module pc_gen #(
    parameter int ADDR_WIDTH  = pc_gen_pkg::ADDR_WIDTH,
    parameter int RESET_PC    = 0,
    parameter int STEP        = pc_gen_pkg::STEP,
    parameter int STALL_WIDTH = 6,
    parameter int STALL_BIT   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [STALL_WIDTH-1:0] stall_i,
    input  logic                   flush_int_i,
    input  logic [ADDR_WIDTH-1:0]  int_pc_i,
    input  logic                   flush_jump_i,
    input  logic [ADDR_WIDTH-1:0]  jump_pc_i,
    input  logic                   ibus_gnt_i,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   ce_o,
    output logic                   ibus_req_o,
    output logic                   misalign_o
);
    import pc_gen_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STEP - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP_INC   = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] PC_INIT    = ADDR_WIDTH'(RESET_PC);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  r_misalign;
    logic                  w_req;
    logic                  w_granted;
    logic                  w_update;
    logic                  w_hold;
    logic                  w_load;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_pend_valid;
    logic [ADDR_WIDTH-1:0] w_pend_target;
    redir_type_e           w_pend_type;

    assign w_req     = (r_state != ST_IDLE);
    assign w_granted = w_req & ibus_gnt_i;
    assign w_update  = w_granted | (r_state == ST_IDLE);
    assign w_hold    = w_req & ~ibus_gnt_i;

    pc_redirect_buf #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_redirect_buf (
        .i_clk        (clk_i),
        .i_rst_n      (rst_n_i),
        .i_hold       (w_hold),
        .i_consume    (w_granted),
        .i_flush_int  (flush_int_i),
        .i_int_pc     (int_pc_i),
        .i_flush_jump (flush_jump_i),
        .i_jump_pc    (jump_pc_i),
        .o_valid      (w_pend_valid),
        .o_target     (w_pend_target),
        .o_type       (w_pend_type)
    );

    // Interrupts (new or pending) outrank jumps; a fresh request beats a pending one of the same kind.
    always_comb begin
        w_load   = 1'b0;
        w_target = '0;
        if (w_update) begin
            if (flush_int_i) begin
                w_load   = 1'b1;
                w_target = int_pc_i;
            end else if (w_pend_valid && (w_pend_type == REDIR_INT)) begin
                w_load   = 1'b1;
                w_target = w_pend_target;
            end else if (flush_jump_i) begin
                w_load   = 1'b1;
                w_target = jump_pc_i;
            end else if (w_pend_valid) begin
                w_load   = 1'b1;
                w_target = w_pend_target;
            end
        end
    end

    always_comb begin
        w_pc_next = r_pc;
        if (w_load) begin
            w_pc_next = w_target & ~ALIGN_MASK;
        end else if (w_granted && !stall_i[STALL_BIT]) begin
            w_pc_next = r_pc + STEP_INC;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     w_state_next = ST_RUN;
            ST_RUN:      w_state_next = ibus_gnt_i ? ST_RUN : ST_WAIT_GNT;
            ST_WAIT_GNT: w_state_next = ibus_gnt_i ? ST_RUN : ST_WAIT_GNT;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_pc       <= PC_INIT;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_misalign <= w_load & (|(w_target & ALIGN_MASK));
        end
    end

    assign pc_o       = r_pc;
    assign ibus_req_o = w_req;
    assign ce_o       = w_req;
    assign misalign_o = r_misalign;

endmodule
